math_addsub_pipe: RTL and testbench

Parametrised, pipelined wide adder/subtractor for the math utility library. It is the successor to the fixed 48-bit adder: operand width is arbitrary and the carry chain is split into registered segments of at most SEG_WIDTH bits, so timing closes at full clock rate for any width. It adds a per-sample add/subtract select, a valid pipeline, a signed-overflow flag and a clock-enable stall. It sits in accumulator, correlator and timestamp datapaths wherever sums wider than 48 bits are required.

---
 rtl/math_pkg.sv | 26 ++
 rtl/math_add_seg.sv | 24 ++
 rtl/math_addsub_pipe.sv | 120 ++++++++++++
 tb/tb_math_addsub_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared helpers for the math utility library: segment count and segment
// span for carry chains split across pipeline stages.
package math_pkg;

  typedef struct packed {
    int base;
    int width;
  } seg_t;

  // Number of segments a WIDTH-bit carry chain breaks into (ceil-divide).
  function automatic int calc_nseg(input int width, input int seg_width);
    return (width + seg_width - 1) / seg_width;
  endfunction

  // Bit span of segment k; the last segment takes whatever bits remain.
  function automatic seg_t seg_span(input int k, input int width, input int seg_width);
    seg_t span;
    int   top;
    top = (k + 1) * seg_width;
    if (top > width) top = width;
    span.base  = k * seg_width;
    span.width = top - span.base;
    return span;
  endfunction

endpackage

// File: rtl/math_add_seg.sv
// One registered carry-chain segment: {cout, sum} <= a + b + cin when enabled.
module math_add_seg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // NOTE: non-blocking assignment so every stage samples pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cout, sum} <= '0;
    end else if (ena) begin
      {cout, sum} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
  end

endmodule

// File: rtl/math_addsub_pipe.sv
// Pipelined wide adder/subtractor: the carry chain is cut into SEG_WIDTH-bit
// registered segments, with operand skew and result de-skew around them.
module math_addsub_pipe
  import math_pkg::*;
#(
  parameter  int WIDTH     = 96,
  parameter  int SEG_WIDTH = 48,
  localparam int NSEG      = calc_nseg(WIDTH, SEG_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             vld_in,
  input  logic             sub,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  output logic             vld_out,
  output logic [WIDTH:0]   dout,
  output logic             ovf
);

  logic [WIDTH-1:0] eff_b;
  logic [WIDTH-1:0] a_skew;
  logic [WIDTH-1:0] b_skew;
  logic [WIDTH-1:0] sum_align;
  logic [NSEG-1:0]  cout_v;
  logic [NSEG-1:0]  vld_sr;
  logic             a_msb_q;
  logic             b_msb_q;

  // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry.
  assign eff_b = sub ? ~dinb : dinb;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam seg_t SPAN   = seg_span(k, WIDTH, SEG_WIDTH);
    localparam int   BASE   = SPAN.base;
    localparam int   SW     = SPAN.width;
    localparam int   DESKEW = NSEG - 1 - k;

    logic [SW-1:0] sum_k;
    logic          cin_k;

    if (k == 0) begin : g_head
      assign a_skew[BASE +: SW] = dina[BASE +: SW];
      assign b_skew[BASE +: SW] = eff_b[BASE +: SW];
      assign cin_k              = sub;
    end else begin : g_skew
      logic [SW-1:0] a_dly [k];
      logic [SW-1:0] b_dly [k];

      // NOTE: delay lines are reset like any other register so flushed samples cannot re-emerge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_dly[i] <= '0;
            b_dly[i] <= '0;
          end
        end else if (ena) begin
          a_dly[0] <= dina[BASE +: SW];
          b_dly[0] <= eff_b[BASE +: SW];
          for (int i = 1; i < k; i++) begin
            a_dly[i] <= a_dly[i-1];
            b_dly[i] <= b_dly[i-1];
          end
        end
      end

      assign a_skew[BASE +: SW] = a_dly[k-1];
      assign b_skew[BASE +: SW] = b_dly[k-1];
      assign cin_k              = cout_v[k-1];
    end

    math_add_seg #(.W(SW)) u_add (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .a    (a_skew[BASE +: SW]),
      .b    (b_skew[BASE +: SW]),
      .cin  (cin_k),
      .sum  (sum_k),
      .cout (cout_v[k])
    );

    if (DESKEW == 0) begin : g_tail
      assign sum_align[BASE +: SW] = sum_k;
    end else begin : g_deskew
      logic [SW-1:0] s_dly [DESKEW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DESKEW; i++) s_dly[i] <= '0;
        end else if (ena) begin
          s_dly[0] <= sum_k;
          for (int i = 1; i < DESKEW; i++) s_dly[i] <= s_dly[i-1];
        end
      end

      assign sum_align[BASE +: SW] = s_dly[DESKEW-1];
    end
  end

  // Operand sign bits ride alongside the last segment for the overflow test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      vld_sr  <= '0;
    end else if (ena) begin
      a_msb_q   <= a_skew[WIDTH-1];
      b_msb_q   <= b_skew[WIDTH-1];
      vld_sr[0] <= vld_in;
      for (int i = 1; i < NSEG; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  assign vld_out = vld_sr[NSEG-1];
  assign dout    = {cout_v[NSEG-1], sum_align};
  assign ovf     = (a_msb_q == b_msb_q) && (sum_align[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_math_addsub_pipe.sv
// Scoreboard bench for math_addsub_pipe at WIDTH 96, 100 and 8 (latency 2, 3, 1),
// all three instances driven from one shared stimulus stream.
module tb_math_addsub_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         vld_in;
  logic         sub;
  logic [127:0] a_in;
  logic [127:0] b_in;

  int n_vec  = 0;
  int n_miss = 0;

  logic         vld_o  [3];
  logic [127:0] dout_o [3];
  logic         ovf_o  [3];
  int           q_left [3];

  typedef struct {
    logic [127:0] dout;
    logic         ovf;
    int           due;
  } exp_t;

  localparam logic [127:0] M96 = (128'h1 << 96) - 128'h1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [127:0] a, input logic [127:0] b,
                                 input logic s);
    logic [127:0] mask, am, eb, full;
    exp_t e;
    mask   = (128'h1 << w) - 128'h1;
    am     = a & mask;
    eb     = (s ? ~b : b) & mask;
    full   = am + eb + {127'b0, s};
    e.dout = full & ((mask << 1) | 128'h1);
    e.ovf  = (am[w-1] == eb[w-1]) && (full[w-1] != am[w-1]);
    e.due  = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W   = (g == 0) ? 96 : (g == 1) ? 100 : 8;
    localparam int LAT = (W + 47) / 48;

    logic [W:0]   dout;
    logic         vld;
    logic         ovf;
    exp_t         q [$];
    int           en_cnt = 0;
    bit           en_edge = 1'b0;
    bit           rst_edge = 1'b0;
    bit           prev_ok = 1'b0;
    logic [127:0] prev_dout;
    logic         prev_vld;
    logic         prev_ovf;

    math_addsub_pipe #(.WIDTH(W), .SEG_WIDTH(48)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .vld_in (vld_in),
      .sub    (sub),
      .dina   (a_in[W-1:0]),
      .dinb   (b_in[W-1:0]),
      .vld_out(vld),
      .dout   (dout),
      .ovf    (ovf)
    );

    assign vld_o[g]  = vld;
    assign dout_o[g] = 128'(dout);
    assign ovf_o[g]  = ovf;

    always @(posedge clk) begin
      exp_t e;
      rst_edge = rst_n;
      en_edge  = rst_n && ena;
      if (en_edge) begin
        en_cnt++;
        if (vld_in) begin
          e     = model(W, a_in, b_in, sub);
          e.due = en_cnt + LAT - 1;
          q.push_back(e);
        end
      end
    end

    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
      exp_t e;
      if (rst_n && rst_edge && !en_edge && prev_ok) begin
        check($sformatf("cfg%0d hold dout", g), dout_o[g], prev_dout);
        check($sformatf("cfg%0d hold vld", g), 128'(vld), 128'(prev_vld));
        check($sformatf("cfg%0d hold ovf", g), 128'(ovf), 128'(prev_ovf));
      end else if (en_edge && vld) begin
        if (q.size() == 0) begin
          check($sformatf("cfg%0d unexpected vld_out", g), 128'(1), 128'(0));
        end else begin
          e = q.pop_front();
          check($sformatf("cfg%0d dout", g), dout_o[g], e.dout);
          check($sformatf("cfg%0d ovf", g), 128'(ovf), 128'(e.ovf));
          check($sformatf("cfg%0d latency", g), 128'(en_cnt), 128'(e.due));
        end
      end
      prev_dout = dout_o[g];
      prev_vld  = vld;
      prev_ovf  = ovf;
      prev_ok   = rst_n;
      q_left[g] = q.size();
    end
  end

  task automatic drive(input logic v, input logic s, input logic [127:0] a, input logic [127:0] b);
    vld_in = v;
    sub    = s;
    a_in   = a;
    b_in   = b;
    @(posedge clk);
    #1;
  endtask

  // One sample through the 96-bit instance, checked against a fixed constant.
  task automatic directed(input string tag, input logic [127:0] a, input logic [127:0] b,
                          input logic s, input logic [127:0] exp_dout, input logic exp_ovf);
    drive(1'b1, s, a, b);
    drive(1'b0, 1'b0, '0, '0);
    check({tag, " vld"}, 128'(vld_o[0]), 128'(1));
    check({tag, " dout"}, dout_o[0], exp_dout);
    check({tag, " ovf"}, 128'(ovf_o[0]), 128'(exp_ovf));
  endtask

  function automatic logic [127:0] rnd128();
    logic [127:0] corner [6];
    corner = '{128'h0, {128{1'b1}}, 128'h1 << 95, (128'h1 << 95) - 128'h1,
               128'h1 << 99, 128'h80};
    if ($urandom_range(0, 5) == 0) return corner[$urandom_range(0, 5)];
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    vld_in = 1'b0;
    sub    = 1'b0;
    a_in   = '0;
    b_in   = '0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("cfg%0d reset vld", g), 128'(vld_o[g]), 128'(0));
      check($sformatf("cfg%0d reset dout", g), dout_o[g], 128'(0));
      check($sformatf("cfg%0d reset ovf", g), 128'(ovf_o[g]), 128'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    directed("carry_out", M96, 128'h1, 1'b0, 128'h1 << 96, 1'b0);
    directed("borrow", 128'h0, 128'h1, 1'b1, M96, 1'b0);
    directed("sub_5_3", 128'h5, 128'h3, 1'b1, (128'h1 << 96) | 128'h2, 1'b0);
    directed("ovf_add", M96 >> 1, 128'h1, 1'b0, 128'h1 << 95, 1'b1);
    directed("ovf_sub", 128'h1 << 95, 128'h1, 1'b1, (128'h1 << 96) | (M96 >> 1), 1'b1);

    // Mixed add/sub stream with a 3-cycle stall; stalled inputs must not be captured.
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        ena = 1'b0;
        repeat (3) drive(1'b1, 1'b1, rnd128(), rnd128());
        ena = 1'b1;
      end
      drive(1'b1, 1'(i), rnd128(), rnd128());
    end
    repeat (4) drive(1'b0, 1'b0, '0, '0);

    // Reset with samples in flight: outputs clear at once and the samples vanish.
    drive(1'b1, 1'b0, rnd128(), rnd128());
    drive(1'b1, 1'b1, rnd128(), rnd128());
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("cfg%0d async vld", g), 128'(vld_o[g]), 128'(0));
      check($sformatf("cfg%0d async dout", g), dout_o[g], 128'(0));
      check($sformatf("cfg%0d async ovf", g), 128'(ovf_o[g]), 128'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vld_in = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, M96, 128'h1);
    repeat (4) drive(1'b0, 1'b0, '0, '0);

    // Random operands, modes, valids and stalls.
    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), rnd128(), rnd128());
    end
    ena = 1'b1;
    repeat (5) drive(1'b0, 1'b0, '0, '0);

    @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("cfg%0d drained", g), 128'(q_left[g]), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
